// File: rtl/integrator_scheduler.sv
// integrator_scheduler
//   Time-shares one integrator neuron among NREQ requesters. An idle
//   scheduler grants one pending requester round-robin, captures its lane
//   operands and enables, presents them to the neuron for a single ISSUE
//   cycle, waits for the neuron result and returns it as a one-cycle,
//   one-hot response strobe.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req[NREQ]             per-requester request level
//   req_x[16*NREQ]        per-requester operands (four 4-bit lanes each)
//   req_w[4*NREQ]         per-requester lane-enable masks
//   gnt[NREQ]             registered one-hot grant, high for the whole operation
//   resp_valid[NREQ]      registered one-hot, one-cycle response strobe
//   resp_f                neuron fire result, held until the next response
//   neuron_x[16]          captured lane operands to the neuron
//   neuron_w[4]           lane enables to the neuron, non-zero only in ISSUE
//   neuron_f              neuron fire output, valid LAT cycles after issue
//   op_cnt[8]             completed operations, wrapping
//   fire_cnt[8]           completed operations that fired, saturating
module integrator_scheduler #(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_x,
  input  logic [4*NREQ-1:0]    req_w,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      resp_valid,
  output logic                 resp_f,
  output logic [15:0]          neuron_x,
  output logic [3:0]           neuron_w,
  input  logic                 neuron_f,
  output logic [7:0]           op_cnt,
  output logic [7:0]           fire_cnt
);

  localparam int PW = $clog2(NREQ);
  // WAIT spans LAT-1 cycles; the counter starts at 0 on entry.
  localparam logic [2:0] WAIT_LAST = 3'(LAT - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t          state;
  state_t          state_nx;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   sel;
  logic            found;
  logic [NREQ-1:0] sel_oh;
  logic [15:0]     opx;
  logic [3:0]      opw;
  logic [2:0]      wcnt;

  // Round-robin search starts at ptr and wraps naturally in PW bits.
  always_comb begin
    state_nx = state;
    found    = 1'b0;
    sel      = ptr;
    sel_oh   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[ptr + PW'(i)]) begin
        found = 1'b1;
        sel   = ptr + PW'(i);
      end
    end
    sel_oh[sel] = 1'b1;
    case (state)
      IDLE:    if (found) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (wcnt == WAIT_LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      gidx       <= '0;
      gnt        <= '0;
      resp_valid <= '0;
      resp_f     <= 1'b0;
      op_cnt     <= 8'd0;
      fire_cnt   <= 8'd0;
      opx        <= '0;
      opw        <= '0;
      wcnt       <= '0;
    end else begin
      state      <= state_nx;
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt  <= sel_oh;
            gidx <= sel;
            opx  <= req_x[{sel, 4'b0000} +: 16];
            opw  <= req_w[{sel, 2'b00} +: 4];
          end
        end
        ISSUE: wcnt <= '0;
        WAIT:  wcnt <= wcnt + 3'd1;
        // Counters update together with the strobe, so they already include
        // the completing operation while resp_valid is high.
        DONE: begin
          resp_valid <= gnt;
          resp_f     <= neuron_f;
          gnt        <= '0;
          ptr        <= gidx + PW'(1);
          op_cnt     <= op_cnt + 8'd1;
          if (neuron_f) fire_cnt <= sat_inc(fire_cnt);
        end
        default: ;
      endcase
    end
  end

  // Reset forces the neuron interface quiet even before the first reset edge.
  assign neuron_w = (state == ISSUE && !reset) ? opw : 4'b0000;
  assign neuron_x = reset ? 16'h0000 : opx;

endmodule

// File: tb/tb_integrator_scheduler.sv
module tb_integrator_scheduler;

  localparam int LAT  = 2;
  localparam int LAT4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [3:0]  req   = '0;
  logic [63:0] req_x = '0;
  logic [15:0] req_w = '0;
  logic [3:0]  gnt, resp_valid;
  logic        resp_f;
  logic [15:0] neuron_x;
  logic [3:0]  neuron_w;
  logic        neuron_f;
  logic [7:0]  op_cnt, fire_cnt;

  logic [3:0]  req4   = '0;
  logic [63:0] req_x4 = '0;
  logic [15:0] req_w4 = '0;
  logic [3:0]  gnt4, resp_valid4;
  logic        resp_f4;
  logic [15:0] neuron_x4;
  logic [3:0]  neuron_w4;
  logic        neuron_f4;
  logic [7:0]  op_cnt4, fire_cnt4;

  integrator_scheduler #(.NREQ(4), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_w(req_w),
    .gnt(gnt), .resp_valid(resp_valid), .resp_f(resp_f),
    .neuron_x(neuron_x), .neuron_w(neuron_w), .neuron_f(neuron_f),
    .op_cnt(op_cnt), .fire_cnt(fire_cnt)
  );

  integrator_scheduler #(.NREQ(4), .LAT(LAT4)) dut4 (
    .clk(clk), .reset(reset), .req(req4), .req_x(req_x4), .req_w(req_w4),
    .gnt(gnt4), .resp_valid(resp_valid4), .resp_f(resp_f4),
    .neuron_x(neuron_x4), .neuron_w(neuron_w4), .neuron_f(neuron_f4),
    .op_cnt(op_cnt4), .fire_cnt(fire_cnt4)
  );

  // Neuron stand-ins: lane registers load on the issue edge (cleared where
  // the enable is 0), fire is valid exactly LAT edges after that.
  logic [3:0] lane  [4];
  logic       fp    [LAT-1];
  logic [3:0] lane4 [4];
  logic       fp4   [LAT4-1];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      lane[k]  <= neuron_w[k]  ? neuron_x[4*k +: 4]  : 4'h0;
      lane4[k] <= neuron_w4[k] ? neuron_x4[4*k +: 4] : 4'h0;
    end
    fp[0]  <= (int'(lane[0]) + int'(lane[1]) + int'(lane[2]) + int'(lane[3])) >= 16;
    fp4[0] <= (int'(lane4[0]) + int'(lane4[1]) + int'(lane4[2]) + int'(lane4[3])) >= 16;
    for (int j = 1; j < LAT - 1; j++)  fp[j]  <= fp[j-1];
    for (int j = 1; j < LAT4 - 1; j++) fp4[j] <= fp4[j-1];
  end
  assign neuron_f  = fp[LAT-2];
  assign neuron_f4 = fp4[LAT4-2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: an operation accepted in idle cycle c occupies c+1..c+LAT+1
  // and responds in cycle c+LAT+2, which is idle again.
  typedef struct {
    int c;
    int g;
    bit f;
    int ops;
    int fires;
  } exp_t;

  exp_t        q[$];
  logic [3:0]  egnt [int];
  logic [3:0]  enw  [int];
  logic [15:0] enx  [int];
  int free_c  = 0;
  int m_ptr   = 0;
  int m_ops   = 0;
  int m_fires = 0;

  function automatic bit ref_fire(input logic [15:0] x, input logic [3:0] w);
    int s = 0;
    for (int k = 0; k < 4; k++) if (w[k]) s += int'(x[4*k +: 4]);
    return s >= 16;
  endfunction

  task automatic model_step(output int granted);
    int c = cyc;
    int g;
    logic [15:0] x;
    logic [3:0]  w;
    bit f;
    granted = -1;
    if (reset) begin
      q.delete(); egnt.delete(); enw.delete(); enx.delete();
      m_ptr = 0; m_ops = 0; m_fires = 0; free_c = c + 1;
      return;
    end
    if (c >= free_c && req != 4'b0000) begin
      g = m_ptr;
      while (!req[g]) g = (g + 1) % 4;
      x = req_x[16*g +: 16];
      w = req_w[4*g +: 4];
      f = ref_fire(x, w);
      for (int j = c + 1; j <= c + LAT + 1; j++) egnt[j] = 4'(1 << g);
      enw[c+1] = w;
      enx[c+1] = x;
      m_ops = (m_ops + 1) % 256;
      if (f && m_fires < 255) m_fires++;
      q.push_back('{c + LAT + 2, g, f, m_ops, m_fires});
      m_ptr   = (g + 1) % 4;
      free_c  = c + LAT + 2;
      granted = g;
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [63:0] x, input logic [15:0] w, input logic rs);
    int gd;
    @(negedge clk);
    reset = rs; req = r; req_x = x; req_w = w;
    model_step(gd);
  endtask

  // Monitor: checks every cycle's outputs against the model's expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("gnt", 64'(gnt), 64'(egnt.exists(cyc) ? egnt[cyc] : 4'b0000));
      chk("neuron_w", 64'(neuron_w), 64'(enw.exists(cyc) ? enw[cyc] : 4'b0000));
      if (enx.exists(cyc)) chk("neuron_x", 64'(neuron_x), 64'(enx[cyc]));
      if (q.size() > 0 && q[0].c == cyc) begin
        e = q.pop_front();
        chk("resp_valid", 64'(resp_valid), 64'(1 << e.g));
        chk("resp_f", 64'(resp_f), 64'(e.f));
        chk("op_cnt", 64'(op_cnt), 64'(e.ops));
        chk("fire_cnt", 64'(fire_cnt), 64'(e.fires));
      end else begin
        chk("resp_valid_idle", 64'(resp_valid), 64'd0);
      end
    end
  end

  // LAT=4 instance: one request, timing checked cycle by cycle.
  bit start4 = 0;
  bit done4  = 0;
  initial begin
    wait (start4);
    @(negedge clk);
    req4 = 4'b0001; req_x4 = 64'h4444; req_w4 = 16'h000F;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      chk("lat4_gnt", 64'(gnt4), (i <= 5) ? 64'd1 : 64'd0);
      chk("lat4_resp_valid", 64'(resp_valid4), (i == 6) ? 64'd1 : 64'd0);
      if (i == 6) begin
        chk("lat4_resp_f", 64'(resp_f4), 64'd1);
        req4 = 4'b0000;
      end
    end
    done4 = 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  logic [63:0] all_ff = 64'hFFFF_FFFF_FFFF_FFFF;
  int st [4];
  int resp_at [4];

  initial begin
    int gd;
    // Reset behaviour
    drive(4'b0000, 64'h0, 16'h0, 1'b1);
    drive(4'b1111, all_ff, 16'hFFFF, 1'b1);
    drive(4'b1111, all_ff, 16'hFFFF, 1'b1);
    chk("rst_neuron_w", 64'(neuron_w), 64'd0);
    chk("rst_neuron_x", 64'(neuron_x), 64'd0);
    chk("rst_op_cnt", 64'(op_cnt), 64'd0);
    chk("rst_fire_cnt", 64'(fire_cnt), 64'd0);
    chk("rst_resp_f", 64'(resp_f), 64'd0);
    drive(4'b0000, 64'h0, 16'h0, 1'b0);
    start4 = 1;

    // Single operation: sum 16 fires, then sum 12 does not.
    for (int i = 0; i < 4; i++) drive(4'b0001, 64'h4444, 16'h000F, 1'b0);
    for (int i = 0; i < 4; i++) drive(4'b0000, 64'h4444, 16'h000F, 1'b0);
    for (int i = 0; i < 4; i++) drive(4'b0001, 64'h4444, 16'h0007, 1'b0);
    for (int i = 0; i < 4; i++) drive(4'b0000, 64'h0, 16'h0, 1'b0);

    // All requesting continuously: rotation 0,1,2,3,0...
    for (int i = 0; i < 22; i++)
      drive(4'b1111, {$urandom, $urandom}, 16'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) drive(4'b0000, 64'h0, 16'h0, 1'b0);

    // Randomized requesters: hold until response, may drop mid-operation,
    // operands change freely whenever not awaiting capture.
    for (int i = 0; i < 4; i++) st[i] = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (st[i] == 2 && cyc == resp_at[i]) begin
          st[i] = 0; req[i] = 1'b0;
        end
        if (st[i] == 0 && $urandom_range(0, 3) == 0) begin
          st[i] = 1; req[i] = 1'b1;
          req_x[16*i +: 16] = 16'($urandom); req_w[4*i +: 4] = 4'($urandom);
        end else if (st[i] != 1) begin
          req_x[16*i +: 16] = 16'($urandom); req_w[4*i +: 4] = 4'($urandom);
          if (st[i] == 2 && $urandom_range(0, 7) == 0) req[i] = 1'b0;
        end
      end
      model_step(gd);
      if (gd >= 0) begin
        st[gd] = 2; resp_at[gd] = cyc + LAT + 2;
      end
    end
    for (int i = 0; i < 8; i++) drive(4'b0000, 64'h0, 16'h0, 1'b0);

    // Reset pulsed during WAIT aborts the operation; first grant after goes to 0.
    drive(4'b0100, 64'h0000_4444_0000_0000, 16'h0F00, 1'b0);
    drive(4'b0100, 64'h0000_4444_0000_0000, 16'h0F00, 1'b0);
    drive(4'b0100, 64'h0000_4444_0000_0000, 16'h0F00, 1'b1);
    for (int i = 0; i < 12; i++) drive(4'b1111, all_ff, 16'hFFFF, 1'b0);

    // Keep firing past 256 operations: op_cnt wraps, fire_cnt saturates.
    for (int i = 0; i < 262 * 4; i++) drive(4'b0001, all_ff, 16'hFFFF, 1'b0);
    for (int i = 0; i < 8; i++) drive(4'b0000, 64'h0, 16'h0, 1'b0);
    chk("sat_fire_cnt", 64'(fire_cnt), 64'd255);
    chk("wrap_op_cnt", 64'(op_cnt), 64'(m_ops));

    chk("drain", 64'(q.size()), 64'd0);
    chk("lat4_done", 64'(done4), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/integrator_scheduler.md
INTEGRATOR_SCHEDULER -- requirements
Module: integrator_scheduler

Interface
REQ-001 Parameter NREQ, default 4 (fixed): number of requesters sharing one integrator neuron.
REQ-002 Parameter LAT, default 2: cycles from the neuron operand issue edge to neuron F being valid; legal range 2..7.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req  input  4  per-requester request, level; held until the requester's resp_valid bit is seen.
REQ-006 req_x  input  64  operands; requester i uses bits [16i+15:16i], four 4-bit lanes, lane k at [16i+4k+3:16i+4k].
REQ-007 req_w  input  16  lane-enable masks; requester i uses bits [4i+3:4i].
REQ-008 gnt  output  4  one-hot grant, registered.
REQ-009 resp_valid  output  4  one-hot, one-cycle response strobe, registered.
REQ-010 resp_f  output  1  neuron fire result; meaningful only while resp_valid != 0.
REQ-011 neuron_x  output  16  lane operands to the neuron, lane k at [4k+3:4k].
REQ-012 neuron_w  output  4  lane enables to the neuron; a 0 bit clears that neuron lane register.
REQ-013 neuron_f  input  1  neuron fire output; 1 when the enabled-lane sum is >= 16.
REQ-014 op_cnt  output  8  completed operations, wrapping counter.
REQ-015 fire_cnt  output  8  completed operations with resp_f=1, saturating counter.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, DONE; encoding is free.
REQ-017 IDLE with req != 0: on the clock edge, select requester g round-robin, searching from ptr upward mod 4.
REQ-018 On that same edge: set gnt to one-hot g, capture req_x/req_w of g into operand registers, and go to ISSUE.
REQ-019 IDLE with req == 0: stay in IDLE, gnt = 0.
REQ-020 ISSUE lasts 1 cycle: neuron_w = captured mask; neuron_x = captured operands; next state WAIT.
REQ-021 neuron_w = 4'b0000 in every state other than ISSUE.
REQ-022 neuron_x holds the captured operands in every state.
REQ-023 WAIT lasts LAT-1 cycles, counted by an internal 3-bit counter; then DONE.
REQ-024 DONE lasts 1 cycle: on its edge, resp_f <= neuron_f, resp_valid <= gnt, gnt <= 0, ptr <= (g+1) mod 4, state <= IDLE.
REQ-025 resp_valid is high for exactly one cycle (the IDLE cycle after DONE); resp_f holds until the next response.
REQ-026 Latency: req sampled in IDLE cycle t gives gnt high in t+1..t+LAT+1 and resp_valid in t+LAT+2.
REQ-027 Back-to-back throughput is one operation per LAT+2 cycles.
REQ-028 A new grant may occur in the same cycle that resp_valid is high.
REQ-029 Requests arriving outside IDLE are not sampled until the next IDLE.
REQ-030 req_x/req_w changes after capture have no effect on the current operation.
REQ-031 If the granted requester drops req mid-operation, the operation still completes and resp_valid still pulses.
REQ-032 On each resp_valid pulse, op_cnt increments by 1, wrapping 255 -> 0.
REQ-033 On each resp_valid pulse with resp_f=1, fire_cnt increments by 1, holding at 255.

Reset
REQ-034 On reset: state = IDLE, ptr = 0, gnt = 0, resp_valid = 0, resp_f = 0, op_cnt = 0, fire_cnt = 0, operand registers = 0, wait counter = 0.
REQ-035 With reset high, neuron_w = 0 and neuron_x = 0.
REQ-036 Reset mid-operation (any state) aborts that operation; no resp_valid is produced for it.
REQ-037 After reset release, the first grant with all requests pending goes to requester 0.

Verification
REQ-038 req=0001, x lanes {4,4,4,4}, w=1111, req high from t -> gnt=0001 in t+1..t+3, resp_valid=0001 and resp_f=1 at t+4 (LAT=2).
REQ-039 Same operands with w=0111 (sum 12) -> resp_f=0 at t+4, fire_cnt unchanged, op_cnt +1.
REQ-040 req=1111 held continuously -> gnt sequence 0001, 0010, 0100, 1000, 0001, each grant 4 cycles apart, each resp_valid one-hot matching its grant.
REQ-041 Reset pulsed during WAIT with req=0100 -> gnt=0 next cycle, no resp_valid; after release with req=1111, first gnt=0001.
REQ-042 256 operations, all fires -> op_cnt returns to 0 and fire_cnt reads 255; a 257th fire leaves fire_cnt at 255.
REQ-043 LAT=4 build, single request at t -> gnt high in t+1..t+5, resp_valid at t+6.
